// File: rtl/rob_entry_queue_pkg.sv
// Shared types for the reorder-buffer entry queue: payload layout and branch encodings.
package rob_pkg;

    localparam int ROB_IDX_MAX = 8;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_COND = 3'd1,
        BR_JAL  = 3'd2,
        BR_JALR = 3'd3,
        BR_CALL = 3'd4,
        BR_RET  = 3'd5
    } branch_type_e;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  opcode;
        logic         exc_valid;
        logic [3:0]   exc_code;
        logic [4:0]   rd;
        logic         rd_en;
        logic [4:0]   frd;
        logic         frd_en;
        logic [11:0]  csr;
        logic         csr_en;
        logic         fflagen;
        branch_type_e branchtype;
        logic         irrevo;
    } rob_payload_t;

endpackage

// File: rtl/rob_entry_queue_if.sv
// Dispatch / writeback / commit bundle of the ROB entry queue.
interface rob_entry_queue_if #(parameter int DEPTH = 16);
    import rob_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic               alloc_valid_i;
    logic               alloc_complete_i;
    rob_payload_t       alloc_data_i;
    logic               full_o;
    logic               empty_o;
    logic [ROB_IDX_MAX-1:0] entrynum_o;
    logic [IDX_W:0]     count_o;
    logic               wb_valid_i;
    logic [ROB_IDX_MAX-1:0] wb_entry_i;
    logic               cmt_valid_o;
    logic               cmt_ready_i;
    rob_payload_t       cmt_data_o;
    logic [ROB_IDX_MAX-1:0] cmt_entrynum_o;
    logic               flush_i;

    // The core side (dispatch, writeback, commit) drives the master end.
    modport master (
        output alloc_valid_i, alloc_complete_i, alloc_data_i,
        output wb_valid_i, wb_entry_i, cmt_ready_i, flush_i,
        input  full_o, empty_o, entrynum_o, count_o,
        input  cmt_valid_o, cmt_data_o, cmt_entrynum_o
    );

    modport slave (
        input  alloc_valid_i, alloc_complete_i, alloc_data_i,
        input  wb_valid_i, wb_entry_i, cmt_ready_i, flush_i,
        output full_o, empty_o, entrynum_o, count_o,
        output cmt_valid_o, cmt_data_o, cmt_entrynum_o
    );

endinterface

// File: rtl/rob_entry_queue_ptr_ctrl.sv
// Wrap-bit read/write pointers of the ROB with full/empty/count and the gated alloc/retire enables.
module rob_ptr_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           alloc_req,
    input  logic           retire_req,
    input  logic           flush,
    output logic [IDX_W:0] wptr,
    output logic [IDX_W:0] rptr,
    output logic           full,
    output logic           empty,
    output logic [IDX_W:0] count,
    output logic           alloc_fire,
    output logic           retire_fire
);

    localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

    assign empty = (wptr == rptr);
    assign full  = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) && (wptr[IDX_W] != rptr[IDX_W]);
    assign count = wptr - rptr;

    // Full is judged on registered pointers, so a same-cycle retire never makes room for an allocation.
    assign alloc_fire  = alloc_req && !full && !flush;
    assign retire_fire = retire_req && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (alloc_fire)
                wptr <= wptr + PTR_ONE;
            if (retire_fire)
                rptr <= rptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/rob_entry_queue.sv
// Reorder-buffer entry queue: in-order allocation, out-of-order completion, in-order commit.
module rob_entry_queue
    import rob_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    rob_entry_queue_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ROB_IDX_MAX-1:0] IDX_MASK = ROB_IDX_MAX'(DEPTH - 1);

    logic [IDX_W:0]   wptr;
    logic [IDX_W:0]   rptr;
    logic [IDX_W:0]   count;
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;
    logic             full;
    logic             empty;
    logic             alloc_fire;
    logic             retire_fire;
    logic             cmt_valid;

    rob_payload_t     payload_q [DEPTH];
    logic [DEPTH-1:0] occ_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] occ_d;
    logic [DEPTH-1:0] done_d;
    logic [DEPTH-1:0] wb_hit;

    assign widx = wptr[IDX_W-1:0];
    assign ridx = rptr[IDX_W-1:0];

    // Commit visibility comes only from registered state, never straight from wb/alloc inputs.
    assign cmt_valid = !empty && done_q[ridx];

    rob_ptr_ctrl #(.IDX_W(IDX_W)) u_ptr_ctrl (
        .clk         (clk_i),
        .rst_n       (arst_ni),
        .alloc_req   (bus.alloc_valid_i),
        .retire_req  (cmt_valid && bus.cmt_ready_i),
        .flush       (bus.flush_i),
        .wptr        (wptr),
        .rptr        (rptr),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .alloc_fire  (alloc_fire),
        .retire_fire (retire_fire)
    );

    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < DEPTH; i++)
            wb_hit[i] = bus.wb_valid_i && ((bus.wb_entry_i & IDX_MASK) == ROB_IDX_MAX'(i));
    end

    // Later assignments override earlier ones: allocation beats writeback, flush beats all.
    always_comb begin
        occ_d  = occ_q;
        done_d = done_q | (wb_hit & occ_q);
        if (retire_fire) begin
            occ_d[ridx]  = 1'b0;
            done_d[ridx] = 1'b0;
        end
        if (alloc_fire) begin
            occ_d[widx]  = 1'b1;
            done_d[widx] = bus.alloc_complete_i;
        end
        if (bus.flush_i) begin
            occ_d  = '0;
            done_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            occ_q  <= '0;
            done_q <= '0;
        end else begin
            occ_q  <= occ_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_fire)
            payload_q[widx] <= bus.alloc_data_i;
    end

    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.count_o        = count;
    assign bus.entrynum_o     = ROB_IDX_MAX'(widx);
    assign bus.cmt_valid_o    = cmt_valid;
    assign bus.cmt_data_o     = payload_q[ridx];
    assign bus.cmt_entrynum_o = ROB_IDX_MAX'(ridx);

endmodule

// File: doc/rob_entry_queue.md
Name: rob_entry_queue

Overview:
- Reorder-buffer storage block directly downstream of the dispatch stage.
- Dispatch allocates one ROB entry per cycle; the block returns the index of the next free entry.
- Execute/writeback units mark entries complete by index.
- The block presents the oldest complete entry in program order to the commit stage through a valid/ready handshake.
- Circular buffer with wrap-bit pointers, per-entry done bits and a synchronous flush.

Parameters:
- DEPTH, 16, number of ROB entries; power of two, 2..256.
- IDX_W, $clog2(DEPTH), entry index width (derived, not overridable).

Ports:
- clk_i  input  1  core clock
- arst_ni  input  1  asynchronous active-low reset
- alloc_valid_i  input  1  dispatch presents an instruction
- alloc_complete_i  input  1  instruction needs no writeback (exception, fence-class); entry is born done
- alloc_data_i  input  rob_payload_t  pc, opcode, exception flags, rd/frd/csr index+enable, fflagen, branchtype, irrevo
- full_o  output  1  no free entry
- empty_o  output  1  no occupied entry
- entrynum_o  output  8  index the next accepted allocation will occupy, zero-extended
- count_o  output  IDX_W+1  occupied entries
- wb_valid_i  input  1  writeback completes an entry
- wb_entry_i  input  8  entry index being completed; upper bits above IDX_W ignored
- cmt_valid_o  output  1  head entry is occupied and done
- cmt_ready_i  input  1  commit stage retires head this cycle
- cmt_data_o  output  rob_payload_t  head entry payload
- cmt_entrynum_o  output  8  head index, zero-extended
- flush_i  input  1  discard all entries (trap/mispredict redirect)

Behaviour:
- Reset is asynchronous on arst_ni low: wptr=rptr=0 including wrap bits, all occ/done bits 0.
  - Reset outputs: full_o=0, empty_o=1, entrynum_o=0, count_o=0, cmt_valid_o=0, cmt_entrynum_o=0.
  - cmt_data_o is don't-care under reset (payload RAM is not reset).
- Pointers are IDX_W+1 bits.
  - empty_o = (wptr == rptr).
  - full_o = index bits equal and wrap bits differ.
  - count_o = wptr - rptr, modulo 2^(IDX_W+1).
- Allocation fires when alloc_valid_i && !full_o.
  - Writes payload at wptr index; sets occ=1 and done=alloc_complete_i.
  - Increments wptr; wrap from DEPTH-1 to 0 toggles the wrap bit.
  - alloc_valid_i while full is ignored; dispatch holds its instruction. No bypass: a commit in the same cycle does not free space for that cycle's allocation.
- Writeback: when wb_valid_i is high and occ[wb_entry_i] is 1, set done. Writeback to an unoccupied index is ignored; it never creates an entry.
- Same-cycle writeback and allocation to the same index: the allocation wins, and done = alloc_complete_i.
- Commit:
  - cmt_valid_o = !empty && done[rptr], driven from registered state only (no combinational path from wb_* or alloc_*).
  - Retire fires on cmt_valid_o && cmt_ready_i: clear occ/done at rptr and increment rptr.
  - At most one retire per cycle. cmt_data_o and cmt_entrynum_o are stable while cmt_valid_o is high and cmt_ready_i is low.
- Latency:
  - Allocation to visible in count_o/full_o/entrynum_o: 1 cycle.
  - Writeback to cmt_valid_o (entry at head): 1 cycle.
  - A done-at-allocation entry into an empty queue: cmt_valid_o in the next cycle.
- Simultaneous allocation and retire, not full: both occur; count_o is unchanged.
- Flush is synchronous and has highest priority.
  - Next cycle: wptr=rptr=0 and all occ/done bits 0.
  - Same-cycle allocation, writeback and retire are all discarded; the commit stage must not count a retire in a flush cycle.
- An arst_ni assertion mid-operation aborts everything immediately, with the reset values above.

Decomposition:
- Package rob_pkg: rob_payload_t struct; ROB_IDX_MAX=8; branchtype encodings.
- One sub-module, rob_ptr_ctrl, is natural. It holds the wrap-bit pointers, full/empty/count and the alloc/retire/flush enables.
- The payload array and occ/done bit vectors stay in the top.

Test Plan:
- After reset, 16 allocations with complete=0 and no writeback → entrynum_o steps 0..15; full_o=1 and count_o=16 after the 16th; a 17th valid is not accepted and entrynum_o stays 0.
- Allocate entries 0,1,2, writeback 2 then 0 → cmt_valid_o goes 1 with cmt_entrynum_o=0; after retire cmt_valid_o=0 (entry 1 not done); writeback 1 → retires 1 then 2 on consecutive cycles.
- Full queue with head done, alloc_valid_i and cmt_ready_i both high → retire only; next cycle count_o=15 and full_o=0; allocation succeeds the following cycle into index 0 with wrap bit toggled.
- Empty queue, allocate with alloc_complete_i=1 and cmt_ready_i=1 → cmt_valid_o=1 exactly one cycle later and retire that cycle; empty_o=1 afterwards.
- Writeback to unoccupied index 5 with queue holding 0..2 → no state change; later allocation into index 5 starts with done=0.
- 8 entries occupied, flush_i together with alloc, writeback and retire → next cycle empty_o=1, count_o=0, entrynum_o=0, cmt_valid_o=0. Repeat with arst_ni pulsed low mid-burst → reset values present immediately.
